// File: rtl/ap_txn_sequencer.sv
// rtl/ap_txn_sequencer.sv - ap_ctrl_hs burst sequencer with gap, outstanding limit, latency and hang checks
//
// Runs a programmed burst of transactions against one kernel's ap_ctrl_hs handshake.
// Ports:
//   clock, reset (async active-low)
//   cfg_go / cfg_num_txn / cfg_gap    : burst launch pulse and its parameters (sampled on accepted go)
//   k_ap_start / k_ap_continue (out)  : kernel handshake drive
//   k_ap_ready / k_ap_done (in)       : kernel handshake response
//   busy, finish                      : burst in progress / one-cycle completion pulse
//   timeout_err, protocol_err         : sticky error flags, cleared by an accepted cfg_go
//   txn_started, txn_done             : per-burst accept and completion counts
//   last_latency, max_latency         : accept-to-done latency of last / worst transaction
module ap_txn_sequencer #(
  parameter int CNT_W       = 16,
  parameter int GAP_W       = 8,
  parameter int MAX_OUT     = 4,
  parameter int TS_W        = 24,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_go,
  input  logic [CNT_W-1:0] cfg_num_txn,
  input  logic [GAP_W-1:0] cfg_gap,
  output logic             k_ap_start,
  input  logic             k_ap_ready,
  input  logic             k_ap_done,
  output logic             k_ap_continue,
  output logic             busy,
  output logic             finish,
  output logic             timeout_err,
  output logic             protocol_err,
  output logic [CNT_W-1:0] txn_started,
  output logic [CNT_W-1:0] txn_done,
  output logic [TS_W-1:0]  last_latency,
  output logic [TS_W-1:0]  max_latency
);

  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int OCC_W = $clog2(MAX_OUT + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GAP, S_DRAIN, S_TMO} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q;
  logic [GAP_W-1:0] gap_cfg_q;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] started_q, started_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [TS_W-1:0]  last_lat_q, last_lat_d;
  logic [TS_W-1:0]  max_lat_q, max_lat_d;
  logic [TS_W-1:0]  ts_q;
  logic [TS_W-1:0]  fifo_q [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             zero_fin_q, zero_fin_d;
  logic             terr_q, terr_d;
  logic             perr_q, perr_d;

  logic             issue_ok, accept, active, done_evt, pop, go_acc;
  logic             progress, tmo_hit, drain_done;
  logic [TS_W-1:0]  pop_ts, latency;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign issue_ok   = (state_q == S_ISSUE) && (occ_q < OCC_W'(MAX_OUT));
  assign accept     = issue_ok && k_ap_ready;
  assign active     = (state_q == S_ISSUE) || (state_q == S_GAP) || (state_q == S_DRAIN);
  assign done_evt   = active && k_ap_done;
  // An accept in the same cycle is pushed first, so a done against an empty FIFO can still pop it.
  assign pop        = done_evt && ((occ_q != '0) || accept);
  assign pop_ts     = (occ_q == '0) ? ts_q : fifo_q[rd_ptr_q];
  assign latency    = ts_q - pop_ts;
  assign go_acc     = (state_q == S_IDLE) && cfg_go;
  assign drain_done = (state_q == S_DRAIN) && (done_q == num_q);
  assign progress   = accept || done_evt;
  // The counter holds cycles elapsed since the last progress cycle, so the
  // timeout fires exactly TIMEOUT_CYC cycles after an accept or done.
  assign tmo_hit    = !progress && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    started_d  = started_q;
    done_d     = done_q;
    last_lat_d = last_lat_q;
    max_lat_d  = max_lat_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    tmo_cnt_d  = '0;
    zero_fin_d = 1'b0;
    terr_d     = terr_q;
    perr_d     = perr_q;
    busy       = 1'b0;
    finish     = zero_fin_q;

    if (go_acc) begin
      started_d  = '0;
      done_d     = '0;
      max_lat_d  = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
      terr_d     = 1'b0;
      perr_d     = 1'b0;
      zero_fin_d = (cfg_num_txn == '0);
    end else begin
      if (accept) begin
        started_d = started_q + 1'b1;
        wr_ptr_d  = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        done_d     = done_q + 1'b1;
        rd_ptr_d   = ptr_inc(rd_ptr_q);
        last_lat_d = latency;
        if (latency > max_lat_q) max_lat_d = latency;
      end else if (k_ap_done) begin
        perr_d = 1'b1;
      end
      occ_d = occ_q + OCC_W'(accept) - OCC_W'(pop);
    end

    case (state_q)
      S_IDLE: begin
        if (go_acc && (cfg_num_txn != '0)) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        busy      = 1'b1;
        tmo_cnt_d = progress ? TMO_W'(1) : tmo_cnt_q + 1'b1;
        if (accept) begin
          if (started_d == num_q) begin
            state_d = S_DRAIN;
          end else if (gap_cfg_q != '0) begin
            state_d   = S_GAP;
            gap_cnt_d = gap_cfg_q;
          end
        end else if (tmo_hit) begin
          state_d = S_TMO;
          terr_d  = 1'b1;
        end
      end
      S_GAP: begin
        busy = 1'b1;
        if (gap_cnt_q <= GAP_W'(1)) state_d = S_ISSUE;
        else gap_cnt_d = gap_cnt_q - 1'b1;
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_d = S_IDLE;
          finish  = 1'b1;
        end else begin
          busy      = 1'b1;
          tmo_cnt_d = progress ? TMO_W'(1) : tmo_cnt_q + 1'b1;
          if (tmo_hit) begin
            state_d = S_TMO;
            terr_d  = 1'b1;
          end
        end
      end
      S_TMO: begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      gap_cfg_q  <= '0;
      gap_cnt_q  <= '0;
      started_q  <= '0;
      done_q     <= '0;
      last_lat_q <= '0;
      max_lat_q  <= '0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      tmo_cnt_q  <= '0;
      zero_fin_q <= 1'b0;
      terr_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_cnt_q  <= gap_cnt_d;
      started_q  <= started_d;
      done_q     <= done_d;
      last_lat_q <= last_lat_d;
      max_lat_q  <= max_lat_d;
      ts_q       <= ts_q + 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      tmo_cnt_q  <= tmo_cnt_d;
      zero_fin_q <= zero_fin_d;
      terr_q     <= terr_d;
      perr_q     <= perr_d;
      if (go_acc) begin
        num_q     <= cfg_num_txn;
        gap_cfg_q <= cfg_gap;
      end
    end
  end

  // Timestamp storage needs no reset: entries are only read once the pointers say they are valid.
  always_ff @(posedge clock) begin
    if (accept) fifo_q[wr_ptr_q] <= ts_q;
  end

  assign k_ap_start    = issue_ok;
  assign k_ap_continue = busy;
  assign timeout_err   = terr_q;
  assign protocol_err  = perr_q;
  assign txn_started   = started_q;
  assign txn_done      = done_q;
  assign last_latency  = last_lat_q;
  assign max_latency   = max_lat_q;

endmodule
